// File: rtl/uart_pkg.sv
// Shared definitions for the oversampled UART receiver: state encoding and default frame geometry.
package uart_pkg;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_STOP_TICKS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line; both stages reset to the idle-high level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/uart_rx_oversampled.sv
// Tick-qualified 8N1-style UART receiver (LSB first) with one-clk rx_done pulse.
// Define UART_RX_SYNC_EN to pass rx through a 2-flop synchroniser (+2 clk sampling latency).
//
// state | meaning
// IDLE  | line idle, waiting for rx low
// START | counting to mid start bit, rejecting glitches
// DATA  | sampling data bits at bit centre, LSB first
// STOP  | waiting out the stop period, then deliver byte
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int STOP_TICKS = DEF_STOP_TICKS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_done,
    output logic                 frame_err
);

    localparam int SW = $clog2((OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS);
    localparam int NW = $clog2(DATA_BITS);

    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(STOP_TICKS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_rx_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (rx),
        .q     (rx_s)
    );
`else
    assign rx_s = rx;
`endif

    rx_state_e            state_q, state_d;
    logic [SW-1:0]        s_cnt_q, s_cnt_d;
    logic [NW-1:0]        n_cnt_q, n_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 rx_done_q, rx_done_d;
    logic                 frame_err_q, frame_err_d;

    always_comb begin
        state_d     = state_q;
        s_cnt_d     = s_cnt_q;
        n_cnt_d     = n_cnt_q;
        shift_d     = shift_q;
        data_out_d  = data_out_q;
        frame_err_d = frame_err_q;
        rx_done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Start edge is taken on any clk so back-to-back frames need no idle gap.
                if (!rx_s) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_cnt_q == S_MID) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_cnt_q == S_BIT) begin
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        s_cnt_d = '0;
                        if (n_cnt_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_cnt_d = n_cnt_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_cnt_q == S_STOP) begin
                        data_out_d  = shift_q;
                        frame_err_d = ~rx_s;
                        rx_done_d   = 1'b1;
                        state_d     = IDLE;
                        s_cnt_d     = '0;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            s_cnt_q     <= '0;
            n_cnt_q     <= '0;
            shift_q     <= '0;
            data_out_q  <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_cnt_q     <= s_cnt_d;
            n_cnt_q     <= n_cnt_d;
            shift_q     <= shift_d;
            data_out_q  <= data_out_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data_out  = data_out_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: directed frames, then randomized bytes, gaps and stop errors.
module tb_uart_rx_oversampled;

    localparam int DB          = 8;
    localparam int OS          = 16;
    localparam int ST          = 16;
    localparam int TICK_DIV    = 4;
    localparam int BIT_CLKS    = OS * TICK_DIV;
    localparam int FRAME_TICKS = OS / 2 + DB * OS + ST;
`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick  = 1'b0;
    logic          rx    = 1'b1;
    logic [DB-1:0] data_out;
    logic          rx_done;
    logic          frame_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [DB-1:0] data;
        logic          ferr;
        int            done_cyc;
    } exp_t;

    exp_t sb[$];

    uart_rx_oversampled dut (
        .clk       (clk),
        .rst       (rst_n),
        .tick      (tick),
        .rx        (rx),
        .data_out  (data_out),
        .rx_done   (rx_done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Tick is raised after the edge numbered cyc (multiple of TICK_DIV), so the DUT sees it on the next edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tick = (cyc % TICK_DIV == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cyc %0d", name, act, exp, cyc);
        end
    endtask

    // rx falls after edge f; the receiver sees it (plus synchroniser delay), then needs half a bit,
    // all data bits and the stop period worth of ticks; rx_done shows in the clk after the last one.
    function automatic int expected_done(input int f);
        int k = f + 1 + SYNC_LAT;
        int n = 0;
        while (n < FRAME_TICKS) begin
            k++;
            if ((k - 1) % TICK_DIV == 0) n++;
        end
        return k;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [DB-1:0] b, input logic stop_bit, input int stop_clks);
        exp_t e;
        e.data     = b;
        e.ferr     = ~stop_bit;
        e.done_cyc = expected_done(cyc);
        sb.push_back(e);
        rx = 1'b0;
        wait_clk(BIT_CLKS);
        for (int i = 0; i < DB; i++) begin
            rx = b[i];
            wait_clk(BIT_CLKS);
        end
        rx = stop_bit;
        wait_clk(stop_clks);
        rx = 1'b1;
    endtask

    task automatic send_bad_stop(input logic [DB-1:0] b);
        send_frame(b, 1'b0, 3 * BIT_CLKS / 4);
        wait_clk(2 * BIT_CLKS);
    endtask

    logic prev_done = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (prev_done) chk("rx_done_single_pulse", {31'd0, rx_done}, 32'd0);
            if (rx_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rx_done actual data=%0h required none at cyc %0d", data_out, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("data_out", {24'd0, data_out}, {24'd0, e.data});
                    chk("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
                    chk("done_cycle", cyc, e.done_cyc);
                end
            end
            prev_done = rx_done;
        end
    end

    initial begin
        #(80000 * 10);
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DB-1:0] b;
        rst_n = 1'b0;
        rx    = 1'b1;
        wait_clk(5);
        chk("reset_data_out", {24'd0, data_out}, 32'd0);
        chk("reset_rx_done", {31'd0, rx_done}, 32'd0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        wait_clk(2 * BIT_CLKS);

        send_frame(8'h55, 1'b1, BIT_CLKS);
        wait_clk(BIT_CLKS);

        send_frame(8'hA3, 1'b1, BIT_CLKS);
        send_frame(8'h0F, 1'b1, BIT_CLKS);
        wait_clk(BIT_CLKS);

        // Start glitch shorter than half a bit must be rejected silently.
        rx = 1'b0;
        wait_clk(3 * TICK_DIV);
        rx = 1'b1;
        wait_clk(2 * BIT_CLKS);
        send_frame(8'h3C, 1'b1, BIT_CLKS);
        wait_clk(BIT_CLKS);

        send_bad_stop(8'h81);
        send_frame(8'h7E, 1'b1, BIT_CLKS);
        wait_clk(BIT_CLKS);

        // Abort 0xFF halfway through data bit 4 with an asynchronous reset.
        b  = 8'hFF;
        rx = 1'b0;
        wait_clk(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            wait_clk(BIT_CLKS);
        end
        rx = b[4];
        wait_clk(BIT_CLKS / 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_data_out", {24'd0, data_out}, 32'd0);
        chk("async_reset_rx_done", {31'd0, rx_done}, 32'd0);
        chk("async_reset_frame_err", {31'd0, frame_err}, 32'd0);
        rx = 1'b1;
        @(posedge clk);
        #1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(2 * BIT_CLKS);
        send_frame(8'h12, 1'b1, BIT_CLKS);
        wait_clk(BIT_CLKS);

        send_frame(8'hC6, 1'b1, BIT_CLKS);
        wait_clk(BIT_CLKS);

        for (int n = 0; n < 16; n++) begin
            b = DB'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) begin
                send_bad_stop(b);
            end else begin
                send_frame(b, 1'b1, BIT_CLKS);
                wait_clk(BIT_CLKS * $urandom_range(0, 2));
            end
        end

        wait_clk(2 * BIT_CLKS);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
- UART receiver stage sitting directly downstream of the baud-rate tick generator.
- Consumes its single-cycle 16x-oversampling tick and the serial rx line; deserialises 8N1-style frames (LSB first).
- Presents each received byte with a one-cycle valid pulse to the debug unit's command/FIFO logic.
- All counting is tick-qualified; clk only clocks state.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..9)
OVERSAMPLE, 16, ticks per bit period; must match generator's 16x
STOP_TICKS, 16, ticks sampled for stop bit (16 = 1 stop bit, 32 = 2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
tick  input  1  one-clk pulse at 16x baud from baud generator
rx  input  1  serial line, idle high
data_out  output  DATA_BITS  last received byte, held until next rx_done
rx_done  output  1  one-clk pulse: data_out valid
frame_err  output  1  stop bit sampled low on last frame; updated with rx_done

Behaviour:
- Reset (rst=0, async): state=IDLE, s_cnt=0, n_cnt=0, shift=0, data_out=0, rx_done=0, frame_err=0. Reset mid-frame aborts it silently; no rx_done.
- s_cnt: log2(max(OVERSAMPLE,STOP_TICKS)) bits; n_cnt: clog2(DATA_BITS) bits. Counters change only on cycles with tick=1 (except clears on state entry).
- IDLE: rx=0 (any clk, tick not required) -> START, s_cnt=0.
- START: on tick, if s_cnt==OVERSAMPLE/2-1 (mid start bit): rx=0 -> DATA, s_cnt=0, n_cnt=0; rx=1 -> glitch, back to IDLE, no output. Else s_cnt++.
- DATA: on tick, if s_cnt==OVERSAMPLE-1: shift={rx, shift[DATA_BITS-1:1]} (LSB first), s_cnt=0; n_cnt==DATA_BITS-1 -> STOP else n_cnt++. Else s_cnt++.
- STOP: on tick, if s_cnt==STOP_TICKS-1: data_out<=shift, frame_err<=~rx, rx_done<=1 for exactly one clk, -> IDLE. Else s_cnt++.
- Byte is delivered even on frame error. rx_done asserts in clk after final stop-sample tick; never two consecutive clks.
- Back-to-back frames: a start edge arriving immediately on return to IDLE is accepted; no idle gap required.
- rx held low continuously (break): frame completes with frame_err=1, data_out=0, then restarts in START.
- tick stuck low: FSM holds state indefinitely; no timeout.

Optional Feature:
- Macro UART_RX_SYNC_EN.
- Defined: rx passes through a 2-flop synchroniser (both flops reset to 1) before the FSM; all sampling latency +2 clk.
- Undefined: rx used directly (caller guarantees synchronous input); zero added latency. Port list identical either way.

Decomposition:
- Package uart_pkg: FSM state encoding (IDLE, START, DATA, STOP, 2-bit), OVERSAMPLE default 16, DATA_BITS default 8.
- One sub-module natural: uart_rx_sync (2-FF synchroniser, async active-low reset to 1), instantiated only under UART_RX_SYNC_EN.

Test Plan:
- Tick every 4 clks (bit = 64 clks); send 0x55, 1 stop -> single rx_done pulse, data_out=0x55, frame_err=0.
- Send 0xA3 then 0x0F back-to-back with no idle gap -> two rx_done pulses, 0xA3 then 0x0F, frame_err=0 both.
- rx low for 3 ticks (shorter than half-bit), then high -> FSM returns to IDLE, no rx_done; following 0x3C frame received correctly.
- Send 0x81 with stop bit driven 0 -> rx_done, data_out=0x81, frame_err=1; next good frame 0x7E clears frame_err=0.
- Assert rst=0 mid-way through data bit 4 of 0xFF -> outputs zero immediately (async), no rx_done; after release, 0x12 received correctly.
- With UART_RX_SYNC_EN defined vs undefined, same 0xC6 frame -> identical data_out; rx_done timing differs by exactly 2 clk.
